// File: rtl/seq_det_pkg.sv
// seq_det_pkg: run state encoding and default pattern/counter widths shared by the detector files
package seq_det_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 4;
endpackage

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: control/config/data bus of the detector; master drives start/abort/cfg_*/x/x_valid, slave returns busy/y/match_cnt/done
interface seq_detect_ctrl_if import seq_det_pkg::*; #(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_limit;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             done;
    modport master (
        output start, abort, cfg_pattern, cfg_overlap, cfg_limit, x, x_valid,
        input  busy, y, match_cnt, done
    );
    modport slave (
        input  start, abort, cfg_pattern, cfg_overlap, cfg_limit, x, x_valid,
        output busy, y, match_cnt, done
    );
endinterface

// File: rtl/seq_match_core.sv
// seq_match_core: bit history, saturating bit count and pattern compare; ports clk/rst_n, clear (new run), shift (valid bit in RUN), x, pattern, overlap -> match (combinational)
module seq_match_core import seq_det_pkg::*; #(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic             x,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pattern,
    output logic             match
);
    localparam int BC_W = $clog2(PAT_W + 1);
    localparam logic [BC_W-1:0] FULL  = BC_W'(PAT_W);
    localparam logic [BC_W-1:0] ARMED = BC_W'(PAT_W - 1);
    // the oldest history bit leaves the compare window as x arrives, so only PAT_W-1 bits are kept
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [BC_W-1:0]  bits_q, bits_d;
    logic [PAT_W-1:0] win;
    assign win = {hist_q, x};
    always_comb begin
        match  = shift && bits_q >= ARMED && win == pattern;
        hist_d = clear ? '0 : shift ? win[PAT_W-2:0] : hist_q;
        bits_d = clear ? '0 : !shift ? bits_q : (match && !overlap) ? '0 : bits_q == FULL ? FULL : bits_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            bits_q <= '0;
        end else begin
            hist_q <= hist_d;
            bits_q <= bits_d;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: IDLE/RUN/DONE run controller with config latch and match counter; ports clk, rst_n (async, active-low), bus (slave modport)
module seq_detect_ctrl import seq_det_pkg::*; #(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst_n,
    seq_detect_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             y_q, y_d;
    logic             arm, shift, match;
    assign arm   = state_q == IDLE && bus.start;
    assign shift = state_q == RUN && bus.x_valid;
    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (arm),
        .shift   (shift),
        .x       (bus.x),
        .overlap (ovl_q),
        .pattern (pat_q),
        .match   (match)
    );
    always_comb begin
        cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d = state_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        lim_d   = lim_q;
        cnt_d   = cnt_q;
        y_d     = 1'b0;
        if (arm) begin
            state_d = RUN;
            pat_d   = bus.cfg_pattern;
            ovl_d   = bus.cfg_overlap;
            lim_d   = bus.cfg_limit;
            cnt_d   = '0;
        end else if (state_q == RUN && bus.abort) begin
            // abort outranks a match arriving in the same cycle
            state_d = IDLE;
        end else if (match) begin
            y_d     = 1'b1;
            cnt_d   = cnt_inc;
            state_d = (lim_q != '0 && cnt_inc == lim_q) ? DONE : RUN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            lim_q   <= '0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end
    assign bus.busy      = state_q == RUN;
    assign bus.done      = state_q == DONE;
    assign bus.y         = y_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed runs with expected pulses queued by the driver and checked by a separate output monitor
module tb_seq_detect_ctrl;
    localparam int PW = 4;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    seq_detect_ctrl_if #(.PAT_W(PW), .CNT_W(CW)) bus ();
    seq_detect_ctrl #(.PAT_W(PW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {
        logic          done;
        logic [CW-1:0] cnt;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int total = 0;
    int bad = 0;
    logic [6:0] s;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && (bus.y || bus.done)) begin
            if (sb.size() == 0) chk("unexpected_y_done", {30'd0, bus.y, bus.done}, 0);
            else begin
                e = sb.pop_front();
                chk("y", {31'd0, bus.y}, 1);
                chk("done", {31'd0, bus.done}, {31'd0, e.done});
                chk("match_cnt_at_y", {28'd0, bus.match_cnt}, {28'd0, e.cnt});
            end
        end
    end
    task automatic send(input logic v, input logic b, input logic ey = 1'b0, input logic ed = 1'b0,
                        input int ec = 0, input logic ab = 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.x_valid = v;
        bus.x = b;
        bus.abort = ab;
        @(posedge clk);
        if (ey) sb.push_back('{ed, CW'(ec)});
    endtask
    task automatic arm(input logic [PW-1:0] pat, input logic ovl, input logic [CW-1:0] lim, input logic xs);
        @(negedge clk);
        bus.cfg_pattern = pat;
        bus.cfg_overlap = ovl;
        bus.cfg_limit = lim;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.x_valid = 1'b1;
        bus.x = xs;
        @(posedge clk);
    endtask
    task automatic abort_run();
        send(0, 0, 0, 0, 0, 1);
        send(0, 0);
        send(0, 0);
    endtask
    task automatic drained(input string name);
        send(0, 0);
        send(0, 0);
        chk(name, sb.size(), 0);
    endtask
    initial begin
        bus.start = 0; bus.abort = 0; bus.cfg_pattern = 0; bus.cfg_overlap = 0;
        bus.cfg_limit = 0; bus.x = 0; bus.x_valid = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_y", {31'd0, bus.y}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_cnt", {28'd0, bus.match_cnt}, 0);
        rst_n = 1'b1;
        // non-overlap, config scrambled mid-run must not matter
        arm(4'b0101, 0, 0, 1);
        @(negedge clk);
        bus.cfg_pattern = 4'b1111; bus.cfg_overlap = 1; bus.cfg_limit = 1; bus.x_valid = 0;
        @(posedge clk);
        send(1, 0); send(1, 1); send(1, 0); send(1, 1, 1, 0, 1); send(1, 0); send(1, 1); send(1, 0);
        send(0, 0); send(0, 0);
        @(negedge clk);
        chk("nonovl_cnt", {28'd0, bus.match_cnt}, 1);
        chk("nonovl_busy", {31'd0, bus.busy}, 1);
        abort_run();
        chk("abort_hold_cnt", {28'd0, bus.match_cnt}, 1);
        chk("abort_idle", {31'd0, bus.busy}, 0);
        drained("nonovl_drain");
        // x_valid in the start cycle is ignored
        arm(4'b0101, 0, 0, 0);
        send(1, 1); send(1, 0); send(1, 1); send(1, 0); send(1, 1, 1, 0, 1);
        abort_run();
        drained("startbit_drain");
        // overlap
        arm(4'b0101, 1, 0, 0);
        send(1, 0); send(1, 1); send(1, 0); send(1, 1, 1, 0, 1); send(1, 0); send(1, 1, 1, 0, 2); send(1, 0);
        send(0, 0);
        @(negedge clk);
        chk("ovl_cnt", {28'd0, bus.match_cnt}, 2);
        abort_run();
        drained("ovl_drain");
        // limit 2 with a start pulse in RUN that must be ignored
        arm(4'b0101, 1, 2, 0);
        send(1, 0); send(1, 1); send(1, 0); send(1, 1, 1, 0, 1);
        @(negedge clk);
        bus.start = 1'b1; bus.x_valid = 1'b0;
        @(posedge clk);
        send(1, 0); send(1, 1, 1, 1, 2);
        send(1, 0); send(1, 1); send(1, 0); send(1, 1); send(1, 0); send(1, 1);
        @(negedge clk);
        chk("limit_busy", {31'd0, bus.busy}, 0);
        chk("limit_cnt", {28'd0, bus.match_cnt}, 2);
        drained("limit_drain");
        // x_valid gaps between every bit
        arm(4'b0101, 0, 0, 0);
        s = 7'b0101010;
        for (int i = 0; i < 7; i++) begin
            send(1, s[6-i], i == 3, 0, 1);
            send(0, 1);
        end
        chk("gap_cnt", {28'd0, bus.match_cnt}, 1);
        abort_run();
        drained("gap_drain");
        // abort coincident with the matching bit
        arm(4'b0101, 0, 0, 0);
        send(1, 0); send(1, 1); send(1, 0); send(1, 1, 0, 0, 0, 1);
        @(negedge clk);
        bus.abort = 1'b0; bus.x_valid = 1'b0;
        chk("abort_match_busy", {31'd0, bus.busy}, 0);
        chk("abort_match_cnt", {28'd0, bus.match_cnt}, 0);
        drained("abort_match_drain");
        // reset mid-run discards the run
        arm(4'b0101, 0, 0, 0);
        send(1, 0); send(1, 1); send(1, 0);
        @(negedge clk);
        bus.x_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, bus.busy}, 0);
        chk("async_rst_cnt", {28'd0, bus.match_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(1, 1); send(1, 0); send(1, 1); send(1, 0); send(1, 1);
        chk("no_rearm_busy", {31'd0, bus.busy}, 0);
        arm(4'b0101, 0, 0, 0);
        send(1, 0); send(1, 1); send(1, 0); send(1, 1, 1, 0, 1); send(1, 0);
        chk("rearm_cnt", {28'd0, bus.match_cnt}, 1);
        abort_run();
        drained("rearm_drain");
        // counter saturation with unlimited run
        arm(4'b1111, 1, 0, 0);
        send(1, 1); send(1, 1); send(1, 1);
        for (int k = 1; k <= 17; k++) send(1, 1, 1, 0, k > 15 ? 15 : k);
        send(0, 0);
        @(negedge clk);
        chk("sat_cnt", {28'd0, bus.match_cnt}, 15);
        chk("sat_busy", {31'd0, bus.busy}, 1);
        abort_run();
        drained("sat_drain");
        // limit 1, first match ends the run
        arm(4'b0011, 0, 1, 0);
        send(1, 0); send(1, 0); send(1, 1); send(1, 1, 1, 1, 1);
        send(1, 0); send(1, 0); send(1, 1); send(1, 1);
        chk("lim1_busy", {31'd0, bus.busy}, 0);
        chk("lim1_cnt", {28'd0, bus.match_cnt}, 1);
        drained("lim1_drain");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
